pixel_compositor: RTL and testbench
===================================

# pixel_compositor

Per-pixel layer compositor feeding `color_mapper`, which splits `color_data` into `VGA_R`, `VGA_G` and `VGA_B`.
- Each cycle it takes the palette indices of the sprite layers covering the current `DrawX`/`DrawY` pixel, plus the background/starfield index.
- It resolves layer priority, looks the winning index up in a writable on-chip palette, and emits a registered 24-bit colour three cycles later.
- Palette updates arrive through a valid/ready port that only accepts writes while no visible pixel is in flight.

## Interface
Parameters:
- `NUM_LAYERS`, 4, number of sprite layers; layer 0 has the highest priority.
- `IDX_W`, 4, palette index width; the palette holds 2^IDX_W entries of 24 bits.
- `BLINK_FRAMES`, 8, frames per blink half-period (used only with `COMPOSITOR_BLINK_EN`).

Ports:
- `Clk` in 1: pixel clock; the only clock.
- `Reset` in 1: reset is synchronous and active-high.
- `frame_start` in 1: one-cycle pulse at the start of each frame.
- `pix_valid` in 1: the current pixel is inside the visible area.
- `layer_idx` in NUM_LAYERS*IDX_W: per-layer index; layer k occupies bits [k*IDX_W +: IDX_W]; index 0 means transparent.
- `bg_idx` in IDX_W: background index, used when all layers are transparent.
- `pal_we` in 1: palette write request (valid).
- `pal_addr` in IDX_W: palette write address.
- `pal_wdata` in 24: palette write data, {R,G,B}.
- `pal_ready` out 1: palette write accepted this cycle when high together with `pal_we`.
- `blink_req` in 1: layer-0 blink enable (present only with `COMPOSITOR_BLINK_EN`).
- `color_data` out 24: {R[23:16], G[15:8], B[7:0]} to `color_mapper`.
- `color_valid` out 1: `color_data` corresponds to a visible pixel.

## Operation
Pipeline stages:
- **S1:** registers `pix_valid`, `layer_idx` and `bg_idx`.
- **S2:** selects the lowest-numbered layer whose index is nonzero; if none is nonzero, selects `bg_idx`. Registers the selected index and the valid bit.
- **S3:** reads the palette entry at the selected index and registers it into `color_data`, registering `color_valid` alongside.
- An invalid pixel produces `color_data` = 24'h000000 and `color_valid` = 0, regardless of its indices.

Palette:
- Stored as 2^IDX_W × 24-bit registers.
- A write commits on the clock edge where `pal_we && pal_ready`.
- `pal_ready` is high iff `pix_valid` is low and the S1 and S2 valid bits are both low. This means no visible pixel is entering or traversing the pipeline, so a palette read and write can never collide.
- `pal_we` while `pal_ready` is low is ignored. The requester holds `pal_we`, `pal_addr` and `pal_wdata` stable until accepted.
- A write takes effect for any pixel whose S3 read occurs on a later cycle.

Boundary conditions:
- **Background index 0:** `bg_idx` = 0 is a valid palette lookup of entry 0, not transparent.
- **All layers opaque:** layer 0 always wins.
- **Reset mid-line:** flushes S1–S3 valid bits to 0 and discards any pending write. Palette contents clear to 0.

## Timing
- Latency is exactly 3 cycles. Inputs sampled at edge N appear on `color_data`/`color_valid` after edge N+2, visible during cycle N+3.
- Throughput is one pixel per cycle, with no stalls.
- Reset values:
  - `color_data` = 0.
  - `color_valid` = 0.
  - `pal_ready` = 1 in the cycle after reset, provided `pix_valid` = 0.
  - All palette entries = 24'h000000.
  - Blink counter = 0 and blink phase = visible.
- `pal_ready` is combinational from `pix_valid` and the S1/S2 valid bits. It falls in the same cycle `pix_valid` rises, and rises two cycles after `pix_valid` falls.

## Configuration
`COMPOSITOR_BLINK_EN`:
- **Defined:**
  - Adds the `blink_req` input and a frame counter that increments on `frame_start`.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 and toggles the blink phase.
  - While `blink_req` = 1 and the phase is hidden, S2 treats layer 0 as transparent.
  - When `blink_req` = 0, the counter and phase reset to 0/visible on the next edge.
  - The phase changes only at a `frame_start` edge, never mid-frame.
- **Undefined:** no `blink_req` port and no counter; layer 0 is always composited.

## Test plan
- Reset, then write entry 3 = 24'hFF0000 while `pix_valid` = 0. Drive `pix_valid` = 1, `layer_idx` = {0,0,0,3} → `color_data` = FF0000 with `color_valid` = 1 exactly 3 cycles later.
- Layers {2,0,5,0} (layer 3 down to layer 0), palette[5] = 00FF00, palette[2] = 0000FF → 00FF00. Then layers all 0 with `bg_idx` = 7 and palette[7] = 101010 → 101010.
- `pal_we` held from the cycle `pix_valid` falls → `pal_ready` is low for 2 cycles. The write commits on the 3rd edge, and the palette entry is unchanged before that.
- Random index stream with `pix_valid` toggling → every `pix_valid` = 0 pixel yields 000000 with `color_valid` = 0. The output matches a reference model delayed by 3.
- Assert `Reset` with 3 valid pixels in flight and `pal_we` held high → `color_valid` = 0 and `color_data` = 0 on the next cycle. The palette is all zero and the held write is not committed on the reset edge.
- With `COMPOSITOR_BLINK_EN`, BLINK_FRAMES = 2, `blink_req` = 1, layer 0 = 1, layer 1 = 2 → the output alternates palette[1] for 2 frames, then palette[2] for 2 frames. It never changes mid-frame.

Source files
------------

// File: rtl/pixel_compositor.sv
// Three-stage layer compositor: priority select over sprite layers, palette lookup, registered colour.
// Optional layer-0 blink is enabled with `define COMPOSITOR_BLINK_EN.
module pixel_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int IDX_W        = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [IDX_W-1:0]            bg_idx,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [23:0]                 pal_wdata,
  output logic                        pal_ready,
`ifdef COMPOSITOR_BLINK_EN
  input  logic                        blink_req,
`endif
  output logic [23:0]                 color_data,
  output logic                        color_valid
);

  localparam int PAL_N = 2**IDX_W;

  logic                        v1;
  logic [NUM_LAYERS*IDX_W-1:0] layer1;
  logic [IDX_W-1:0]            bg1;
  logic                        v2;
  logic [IDX_W-1:0]            sel2;
  logic [IDX_W-1:0]            sel;
  logic                        found;
  logic                        mask0;
  logic [23:0]                 pal [PAL_N];

  // No visible pixel entering or in S1/S2, so an S3 read can never meet a write.
  assign pal_ready = !pix_valid && !v1 && !v2;

`ifdef COMPOSITOR_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {VISIBLE = 1'b0, HIDDEN = 1'b1} phase_t;

  phase_t        phase;
  logic [CW-1:0] blink_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || !blink_req) begin
      blink_cnt <= '0;
      phase     <= VISIBLE;
    end else if (frame_start) begin
      if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        phase     <= (phase == VISIBLE) ? HIDDEN : VISIBLE;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign mask0 = blink_req && (phase == HIDDEN);
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign mask0 = 1'b0;
`endif

  always_comb begin
    sel   = bg1;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (!found && (layer1[k*IDX_W +: IDX_W] != '0) && !(k == 0 && mask0)) begin
        sel   = layer1[k*IDX_W +: IDX_W];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1          <= 1'b0;
      layer1      <= '0;
      bg1         <= '0;
      v2          <= 1'b0;
      sel2        <= '0;
      color_data  <= '0;
      color_valid <= 1'b0;
    end else begin
      v1          <= pix_valid;
      layer1      <= layer_idx;
      bg1         <= bg_idx;
      v2          <= v1;
      sel2        <= sel;
      color_data  <= v2 ? pal[sel2] : '0;
      color_valid <= v2;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < PAL_N; i++) pal[i] <= '0;
    end else if (pal_we && pal_ready) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor: latency, priority, palette handshake, reset.
module tb_pixel_compositor;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] layer_idx = '0;
  logic [3:0]  bg_idx = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [23:0] pal_wdata = '0;
  logic        pal_ready;
  logic [23:0] color_data;
  logic        color_valid;
`ifdef COMPOSITOR_BLINK_EN
  logic        blink_req = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] pal_m [16];
  logic [24:0] exp_q [$];

  pixel_compositor #(.NUM_LAYERS(4), .IDX_W(4), .BLINK_FRAMES(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .layer_idx   (layer_idx),
    .bg_idx      (bg_idx),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .pal_ready   (pal_ready),
`ifdef COMPOSITOR_BLINK_EN
    .blink_req   (blink_req),
`endif
    .color_data  (color_data),
    .color_valid (color_valid)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] model(input logic v, input logic [15:0] layers, input logic [3:0] bg);
    logic [3:0] idx;
    if (!v) return '0;
    if      (layers[3:0]   != 0) idx = layers[3:0];
    else if (layers[7:4]   != 0) idx = layers[7:4];
    else if (layers[11:8]  != 0) idx = layers[11:8];
    else if (layers[15:12] != 0) idx = layers[15:12];
    else                         idx = bg;
    return {1'b1, pal_m[idx]};
  endfunction

  // Drive one pixel; output seen after this tick belongs to the pixel driven three ticks ago.
  task automatic drive_pix(input logic v, input logic [15:0] layers, input logic [3:0] bg);
    logic [24:0] e;
    pix_valid = v;
    layer_idx = layers;
    bg_idx    = bg;
    exp_q.push_back(model(v, layers, bg));
    tick();
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check("pix", {7'b0, color_valid, color_data}, {7'b0, e});
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) drive_pix(1'b0, 16'h0, 4'h0);
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
    int waited;
    pal_we    = 1'b1;
    pal_addr  = a;
    pal_wdata = d;
    waited    = 0;
    while (!pal_ready && waited < 10) begin
      tick();
      waited++;
    end
    if (!pal_ready) check("pal_ready_timeout", 32'(pal_ready), 32'd1);
    tick();
    pal_we   = 1'b0;
    pal_m[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal_m[i] = '0;

    tick(); tick();
    Reset = 1'b0;
    check("rst_data",  {8'b0, color_data}, 32'h0);
    check("rst_valid", 32'(color_valid), 32'd0);
    check("rst_ready", 32'(pal_ready), 32'd1);

    // Exact 3-cycle latency
    pal_write(4'd3, 24'hFF0000);
    pix_valid = 1'b1; layer_idx = 16'h0003; bg_idx = 4'd0;
    tick();
    pix_valid = 1'b0; layer_idx = 16'h0;
    tick();
    check("lat_early", 32'(color_valid), 32'd0);
    tick();
    check("lat_data",  {8'b0, color_data}, 32'h00FF0000);
    check("lat_valid", 32'(color_valid), 32'd1);
    tick();
    check("lat_after", 32'(color_valid), 32'd0);

    // Priority, background, background index 0, all opaque
    pal_write(4'd5, 24'h00FF00);
    pal_write(4'd2, 24'h0000FF);
    pal_write(4'd7, 24'h101010);
    pal_write(4'd0, 24'hABCDEF);
    drive_pix(1'b1, 16'h2050, 4'd7);
    drive_pix(1'b1, 16'h0000, 4'd7);
    drive_pix(1'b1, 16'h0000, 4'd0);
    drive_pix(1'b1, 16'h2553, 4'd7);
    drive_pix(1'b0, 16'h2553, 4'd7);
    drive_pix(1'b1, 16'h5200, 4'd0);
    flush();

    // Handshake: ready falls with pix_valid, rises two cycles after it falls
    pix_valid = 1'b1; layer_idx = 16'h0; bg_idx = 4'd9;
    pal_we = 1'b1; pal_addr = 4'd10; pal_wdata = 24'hDEAD00;
    #1;
    check("rdy_rise_pix", 32'(pal_ready), 32'd0);
    tick();
    pix_valid = 1'b0; pal_addr = 4'd9; pal_wdata = 24'h123456;
    #1;
    check("rdy_wait1", 32'(pal_ready), 32'd0);
    tick();
    check("rdy_wait2", 32'(pal_ready), 32'd0);
    tick();
    check("rdy_up", 32'(pal_ready), 32'd1);
    check("pre_commit_data",  {8'b0, color_data}, 32'h0);
    check("pre_commit_valid", 32'(color_valid), 32'd1);
    tick();
    pal_we = 1'b0;
    pal_m[9] = 24'h123456;
    drive_pix(1'b1, 16'h0, 4'd9);
    drive_pix(1'b1, 16'h0, 4'd10);
    flush();

    // Random stream with toggling pix_valid
    for (int i = 0; i < 40; i++)
      drive_pix(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
    flush();

`ifdef COMPOSITOR_BLINK_EN
    pal_write(4'd1, 24'h0000AA);
    pal_write(4'd2, 24'h00BB00);
    blink_req = 1'b1;
    pix_valid = 1'b1; layer_idx = 16'h0021; bg_idx = 4'd0;
    for (int f = 1; f <= 6; f++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int c = 2; c <= 6; c++) begin
        tick();
        if (c == 4 || c == 6)
          check("blink", {8'b0, color_data},
                {8'b0, (((f / 2) % 2) == 1) ? 24'h00BB00 : 24'h0000AA});
      end
    end
    pix_valid = 1'b0; layer_idx = 16'h0; blink_req = 1'b0;
    tick(); tick(); tick();
`endif

    // Reset with pixels in flight and a held write
    pix_valid = 1'b1; layer_idx = 16'h0003; tick();
    layer_idx = 16'h0050; tick();
    layer_idx = 16'h0000; bg_idx = 4'd7; tick();
    pix_valid = 1'b0;
    pal_we = 1'b1; pal_addr = 4'd4; pal_wdata = 24'h777777;
    Reset = 1'b1;
    tick();
    check("rstmid_valid", 32'(color_valid), 32'd0);
    check("rstmid_data",  {8'b0, color_data}, 32'h0);
    tick();
    pal_we = 1'b0;
    Reset  = 1'b0;
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) drive_pix(1'b1, 16'h0, 4'(i));
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
